// File: rtl/io_dev_arbiter_pkg.sv
// Shared definitions for the I/O device arbiter: character width, device
// indices and the input/output FSM state encodings.
package io_dev_arbiter_pkg;

   localparam int CHAR_W = 5;
   typedef logic [CHAR_W-1:0] char_t;

   // Reader indices (input side)
   localparam logic RDR_PHOTO = 1'b0;
   localparam logic RDR_HOST  = 1'b1;

   // Writer indices (output side)
   localparam int WR_PRINTER = 0;
   localparam int WR_PUNCH   = 1;

   typedef enum logic [1:0] {I_IDLE, I_WAIT, I_VAL, I_DROP} in_state_t;
   typedef enum logic [1:0] {O_IDLE, O_SEND, O_ACK, O_REL} out_state_t;

   // One-hot ready vector for a single reader index
   function automatic logic [1:0] dev_bit(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/io_dev_arbiter_if.sv
// Handshake bundle between the arbiter, the I/O unit, the devices and the panel.
interface io_dev_arbiter_if;
   import io_dev_arbiter_pkg::*;

   // I/O unit, input direction
   logic       input_rdy_from_io;
   logic       input_val_to_io;
   char_t      input_data_to_io;
   // I/O unit, output direction
   logic       output_rdy_from_io;
   char_t      output_data_from_io;
   logic       output_ack_to_io;
   // Readers
   logic [1:0] in_rdy_to_dev;
   logic [1:0] in_val_from_dev;
   char_t      in_data_from_dev0;
   char_t      in_data_from_dev1;
   // Writers
   logic [1:0] out_rdy_to_dev;
   char_t      out_data_to_dev;
   logic [1:0] out_ack_from_dev;
   // Panel
   logic [1:0] in_enable_from_pnl;
   logic [1:0] out_enable_from_pnl;
   logic       clear_fault_from_pnl;
   logic [1:0] out_fault_to_pnl;
   logic       in_busy_to_pnl;
   logic       out_busy_to_pnl;

   // Arbiter side
   modport master (
      input  input_rdy_from_io, output_rdy_from_io, output_data_from_io,
             in_val_from_dev, in_data_from_dev0, in_data_from_dev1,
             out_ack_from_dev, in_enable_from_pnl, out_enable_from_pnl,
             clear_fault_from_pnl,
      output input_val_to_io, input_data_to_io, output_ack_to_io,
             in_rdy_to_dev, out_rdy_to_dev, out_data_to_dev,
             out_fault_to_pnl, in_busy_to_pnl, out_busy_to_pnl
   );

   // Environment side (I/O unit, devices, panel)
   modport slave (
      output input_rdy_from_io, output_rdy_from_io, output_data_from_io,
             in_val_from_dev, in_data_from_dev0, in_data_from_dev1,
             out_ack_from_dev, in_enable_from_pnl, out_enable_from_pnl,
             clear_fault_from_pnl,
      input  input_val_to_io, input_data_to_io, output_ack_to_io,
             in_rdy_to_dev, out_rdy_to_dev, out_data_to_dev,
             out_fault_to_pnl, in_busy_to_pnl, out_busy_to_pnl
   );

endinterface

// File: rtl/io_out_lane.sv
// Per-writer bookkeeping: 'done' for the character in flight and a sticky
// timeout fault flag. done_next is the done bit including this cycle's ack,
// so the output FSM can decide completion in the same cycle.
module io_out_lane (
   input  logic clk,
   input  logic resetn,
   input  logic mask,          // writer takes part in the current character
   input  logic ack,           // writer acknowledge
   input  logic sending,       // output FSM is in O_SEND
   input  logic release_done,  // O_REL is being left: forget done
   input  logic timeout,       // watchdog expired this cycle
   input  logic clear_fault,   // panel clear pulse
   output logic done_next,
   output logic fault
);

   logic done;
   logic fault_set;

   // Acks from writers outside the mask never count
   assign done_next = done | (sending & mask & ack);
   assign fault_set = timeout & mask & ~done_next;

   // Track completion and latch the sticky fault; a coincident set beats clear
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!resetn) begin
         done  <= 1'b0;
         fault <= 1'b0;
      end else begin
         done  <= release_done ? 1'b0 : done_next;
         fault <= fault_set | (fault & ~clear_fault);
      end
   end

endmodule

// File: rtl/io_dev_arbiter.sv
// Arbitrates two character readers onto the I/O unit's input channel
// (round-robin) and broadcasts the I/O unit's output characters to the
// enabled writers, with a watchdog that faults writers which never ack.
// The two directions are fully independent FSMs.
module io_dev_arbiter
   import io_dev_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11     // >= clog2(TIMEOUT_CYCLES)+1
) (
   input logic              clk,
   input logic              resetn,
   io_dev_arbiter_if.master bus
);

   // Last watchdog value before expiry: the increment on this cycle reaches TIMEOUT_CYCLES
   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   // ---------------- input side ----------------
   in_state_t  i_state;
   logic       last_grant;
   logic       grant;
   logic       pick;
   logic [1:0] in_rdy_q;
   logic       in_val_q;
   char_t      in_data_q;
   logic       in_busy_q;
   char_t      sel_data;

   assign sel_data = (grant == RDR_PHOTO) ? bus.in_data_from_dev0 : bus.in_data_from_dev1;

   // Prefer the reader that was not served last; fall back to the only enabled one
   always_comb begin
      // NOTE: default assigned first so no latch is inferred.
      pick = last_grant;
      if (bus.in_enable_from_pnl[~last_grant]) pick = ~last_grant;
   end

   // Input FSM: grant a reader, capture its character, offer it to the I/O unit
   always_ff @(posedge clk) begin
      if (!resetn) begin
         i_state    <= I_IDLE;
         last_grant <= RDR_HOST;
         grant      <= RDR_PHOTO;
         in_rdy_q   <= '0;
         in_val_q   <= 1'b0;
         in_data_q  <= '0;
         in_busy_q  <= 1'b0;
      end else begin
         case (i_state)
            I_IDLE: if (bus.input_rdy_from_io && (bus.in_enable_from_pnl != 2'b00)) begin
               grant     <= pick;
               in_rdy_q  <= dev_bit(pick);
               in_busy_q <= 1'b1;
               i_state   <= I_WAIT;
            end
            I_WAIT: if (!bus.in_enable_from_pnl[grant] || !bus.input_rdy_from_io) begin
               in_rdy_q  <= '0;
               in_busy_q <= 1'b0;
               i_state   <= I_IDLE;
            end else if (bus.in_val_from_dev[grant]) begin
               in_rdy_q  <= '0;
               in_val_q  <= 1'b1;
               in_data_q <= sel_data;
               i_state   <= I_VAL;
            end
            I_VAL: if (!bus.input_rdy_from_io) begin
               in_val_q  <= 1'b0;
               in_data_q <= '0;
               i_state   <= I_DROP;
            end
            I_DROP: if (!bus.in_val_from_dev[grant]) begin
               last_grant <= grant;
               in_busy_q  <= 1'b0;
               i_state    <= I_IDLE;
            end
            default: i_state <= I_IDLE;
         endcase
      end
   end

   assign bus.in_rdy_to_dev    = in_rdy_q;
   assign bus.input_val_to_io  = in_val_q;
   assign bus.input_data_to_io = in_data_q;
   assign bus.in_busy_to_pnl   = in_busy_q;

   // ---------------- output side ----------------
   out_state_t      o_state;
   logic [1:0]      mask;
   logic [TO_W-1:0] wdog;
   logic [1:0]      out_rdy_q;
   char_t           out_data_q;
   logic            out_ack_q;
   logic            out_busy_q;
   logic [1:0]      done_next;
   logic [1:0]      fault;
   logic            sending;
   logic            release_done;
   logic            wd_fire;

   assign sending      = (o_state == O_SEND);
   assign release_done = (o_state == O_REL) && ((bus.out_ack_from_dev & mask) == 2'b00);
   assign wd_fire      = sending && (wdog == WD_LAST) && (done_next != mask);

   io_out_lane u_lane_printer (
      .clk         (clk),
      .resetn      (resetn),
      .mask        (mask[WR_PRINTER]),
      .ack         (bus.out_ack_from_dev[WR_PRINTER]),
      .sending     (sending),
      .release_done(release_done),
      .timeout     (wd_fire),
      .clear_fault (bus.clear_fault_from_pnl),
      .done_next   (done_next[WR_PRINTER]),
      .fault       (fault[WR_PRINTER])
   );

   io_out_lane u_lane_punch (
      .clk         (clk),
      .resetn      (resetn),
      .mask        (mask[WR_PUNCH]),
      .ack         (bus.out_ack_from_dev[WR_PUNCH]),
      .sending     (sending),
      .release_done(release_done),
      .timeout     (wd_fire),
      .clear_fault (bus.clear_fault_from_pnl),
      .done_next   (done_next[WR_PUNCH]),
      .fault       (fault[WR_PUNCH])
   );

   // Output FSM: snapshot enables, broadcast until every masked writer acks or the watchdog expires
   always_ff @(posedge clk) begin
      if (!resetn) begin
         o_state    <= O_IDLE;
         mask       <= '0;
         wdog       <= '0;
         out_rdy_q  <= '0;
         out_data_q <= '0;
         out_ack_q  <= 1'b0;
         out_busy_q <= 1'b0;
      end else begin
         case (o_state)
            O_IDLE: if (bus.output_rdy_from_io) begin
               mask       <= bus.out_enable_from_pnl;
               out_data_q <= bus.output_data_from_io;
               out_busy_q <= 1'b1;
               if (bus.out_enable_from_pnl != 2'b00) begin
                  wdog      <= '0;
                  out_rdy_q <= bus.out_enable_from_pnl;
                  o_state   <= O_SEND;
               end else begin
                  // No writer enabled: the character is swallowed
                  out_ack_q <= 1'b1;
                  o_state   <= O_ACK;
               end
            end
            O_SEND: begin
               wdog <= wdog + 1'b1;
               if (done_next == mask) begin
                  out_rdy_q <= '0;
                  out_ack_q <= 1'b1;
                  o_state   <= O_ACK;
               end else if (wd_fire) begin
                  // Silent writers drop out so O_REL does not wait on them
                  mask      <= mask & done_next;
                  out_rdy_q <= '0;
                  out_ack_q <= 1'b1;
                  o_state   <= O_ACK;
               end else begin
                  out_rdy_q <= mask & ~done_next;
               end
            end
            O_ACK: if (!bus.output_rdy_from_io) begin
               out_ack_q <= 1'b0;
               o_state   <= O_REL;
            end
            O_REL: if (release_done) begin
               out_data_q <= '0;
               out_busy_q <= 1'b0;
               o_state    <= O_IDLE;
            end
            default: o_state <= O_IDLE;
         endcase
      end
   end

   assign bus.out_rdy_to_dev   = out_rdy_q;
   assign bus.out_data_to_dev  = out_data_q;
   assign bus.output_ack_to_io = out_ack_q;
   assign bus.out_busy_to_pnl  = out_busy_q;
   assign bus.out_fault_to_pnl = fault;

endmodule

// File: tb/tb_io_dev_arbiter.sv
// Bench for io_dev_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a behavioural transfer model that
// is compared against every DUT output on every falling clock edge.
module tb_io_dev_arbiter;

   localparam int TB_TIMEOUT = 16;

   // Model phases, named after the handshake step each direction is in
   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;   // input: reader granted / output: broadcasting
   localparam int PH_VAL  = 2;   // input: char offered  / output: acking io
   localparam int PH_DROP = 3;   // input: waiting val low / output: waiting acks low

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   io_dev_arbiter_if bus ();

   io_dev_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT), .TO_W(5)) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit         m_valid = 0;
   int         m_iph, m_g, m_lg;
   logic [4:0] m_idat;
   int         m_oph, m_wd;
   logic [1:0] m_mask, m_done, m_fault;
   logic [4:0] m_odat;

   task automatic model_step();
      logic [1:0] set;
      logic [1:0] ien;
      ien = bus.in_enable_from_pnl;
      set = 2'b00;
      if (!resetn) begin
         m_valid = 1;
         m_iph = PH_IDLE; m_g = 0; m_lg = 1; m_idat = '0;
         m_oph = PH_IDLE; m_wd = 0; m_mask = '0; m_done = '0; m_fault = '0; m_odat = '0;
      end else begin
         // reader -> io
         case (m_iph)
            PH_IDLE: if (bus.input_rdy_from_io && ien != 2'b00) begin
               m_g   = ien[1 - m_lg] ? 1 - m_lg : m_lg;
               m_iph = PH_WAIT;
            end
            PH_WAIT: if (!ien[m_g] || !bus.input_rdy_from_io) m_iph = PH_IDLE;
                     else if (bus.in_val_from_dev[m_g]) begin
                        m_idat = (m_g == 0) ? bus.in_data_from_dev0 : bus.in_data_from_dev1;
                        m_iph  = PH_VAL;
                     end
            PH_VAL:  if (!bus.input_rdy_from_io) m_iph = PH_DROP;
            default: if (!bus.in_val_from_dev[m_g]) begin m_lg = m_g; m_iph = PH_IDLE; end
         endcase
         // io -> writers
         case (m_oph)
            PH_IDLE: if (bus.output_rdy_from_io) begin
               m_odat = bus.output_data_from_io;
               m_mask = bus.out_enable_from_pnl;
               m_wd   = 0;
               m_oph  = (m_mask != 2'b00) ? PH_WAIT : PH_VAL;
            end
            PH_WAIT: begin
               m_done = m_done | (bus.out_ack_from_dev & m_mask);
               m_wd   = m_wd + 1;
               if (m_done == m_mask) m_oph = PH_VAL;
               else if (m_wd == TB_TIMEOUT) begin
                  set    = m_mask & ~m_done;
                  m_mask = m_mask & m_done;
                  m_oph  = PH_VAL;
               end
            end
            PH_VAL:  if (!bus.output_rdy_from_io) m_oph = PH_DROP;
            default: if ((bus.out_ack_from_dev & m_mask) == 2'b00) begin
               m_done = '0;
               m_oph  = PH_IDLE;
            end
         endcase
         m_fault = set | (m_fault & ~{2{bus.clear_fault_from_pnl}});
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: the model advances on the same edge as the DUT
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Compare every output against the model each cycle
   always @(negedge clk) begin
      if (m_valid) begin
         check("in_rdy_to_dev", 32'(bus.in_rdy_to_dev),
               (m_iph == PH_WAIT) ? (32'd1 << m_g) : 32'd0);
         check("input_val_to_io", 32'(bus.input_val_to_io), 32'(m_iph == PH_VAL));
         check("input_data_to_io", 32'(bus.input_data_to_io),
               (m_iph == PH_VAL) ? 32'(m_idat) : 32'd0);
         check("in_busy_to_pnl", 32'(bus.in_busy_to_pnl), 32'(m_iph != PH_IDLE));
         check("out_rdy_to_dev", 32'(bus.out_rdy_to_dev),
               (m_oph == PH_WAIT) ? 32'(m_mask & ~m_done) : 32'd0);
         check("out_data_to_dev", 32'(bus.out_data_to_dev),
               (m_oph == PH_IDLE) ? 32'd0 : 32'(m_odat));
         check("output_ack_to_io", 32'(bus.output_ack_to_io), 32'(m_oph == PH_VAL));
         check("out_busy_to_pnl", 32'(bus.out_busy_to_pnl), 32'(m_oph != PH_IDLE));
         check("out_fault_to_pnl", 32'(bus.out_fault_to_pnl), 32'(m_fault));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_idle();
      bus.input_rdy_from_io    = 1'b0;
      bus.output_rdy_from_io   = 1'b0;
      bus.output_data_from_io  = '0;
      bus.in_val_from_dev      = '0;
      bus.in_data_from_dev0    = '0;
      bus.in_data_from_dev1    = '0;
      bus.out_ack_from_dev     = '0;
      bus.in_enable_from_pnl   = '0;
      bus.out_enable_from_pnl  = '0;
      bus.clear_fault_from_pnl = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_rdy"},   32'(bus.in_rdy_to_dev), 32'd0);
      check({tag, "_ival"},     32'(bus.input_val_to_io), 32'd0);
      check({tag, "_idata"},    32'(bus.input_data_to_io), 32'd0);
      check({tag, "_out_rdy"},  32'(bus.out_rdy_to_dev), 32'd0);
      check({tag, "_out_data"}, 32'(bus.out_data_to_dev), 32'd0);
      check({tag, "_oack"},     32'(bus.output_ack_to_io), 32'd0);
      check({tag, "_fault"},    32'(bus.out_fault_to_pnl), 32'd0);
      check({tag, "_in_busy"},  32'(bus.in_busy_to_pnl), 32'd0);
      check({tag, "_out_busy"}, 32'(bus.out_busy_to_pnl), 32'd0);
   endtask

   logic [4:0] rr_char [3] = '{5'h12, 5'h05, 5'h12};
   logic [1:0] rr_rdy  [3] = '{2'b01, 2'b10, 2'b01};

   initial begin
      int         cnt;
      logic [1:0] dead;
      logic [1:0] vals;
      logic [1:0] acks;

      drive_idle();
      resetn = 1'b0;
      repeat (3) cycle();
      check_all_zero("reset");
      resetn = 1'b1;

      // First grant after reset goes to the photo-reader
      bus.in_enable_from_pnl = 2'b11;
      bus.input_rdy_from_io  = 1'b1;
      cycle();
      check("first_grant", 32'(bus.in_rdy_to_dev), 32'h1);
      bus.input_rdy_from_io = 1'b0;
      cycle();

      // Round-robin between two always-valid readers
      bus.in_data_from_dev0 = 5'h12;
      bus.in_data_from_dev1 = 5'h05;
      for (int i = 0; i < 3; i++) begin
         bus.input_rdy_from_io = 1'b1;
         bus.in_val_from_dev   = 2'b11;
         cycle();
         check("rr_grant", 32'(bus.in_rdy_to_dev), 32'(rr_rdy[i]));
         cycle();
         check("rr_val", 32'(bus.input_val_to_io), 32'd1);
         check("rr_char", 32'(bus.input_data_to_io), 32'(rr_char[i]));
         bus.input_rdy_from_io = 1'b0;
         cycle();
         bus.in_val_from_dev = 2'b00;
         cycle();
         check("rr_idle", 32'(bus.in_busy_to_pnl), 32'd0);
      end

      // Disable the only granted reader while it is being waited on
      bus.in_enable_from_pnl = 2'b10;
      bus.input_rdy_from_io  = 1'b1;
      cycle();
      check("dis_grant", 32'(bus.in_rdy_to_dev), 32'h2);
      bus.in_enable_from_pnl = 2'b00;
      cycle();
      check("dis_busy", 32'(bus.in_busy_to_pnl), 32'd0);
      check("dis_rdy", 32'(bus.in_rdy_to_dev), 32'd0);
      cycle();
      check("dis_val", 32'(bus.input_val_to_io), 32'd0);
      bus.input_rdy_from_io = 1'b0;

      // Broadcast to both writers; printer acks in send cycle 3, punch in 9
      bus.out_enable_from_pnl = 2'b11;
      bus.output_data_from_io = 5'h16;
      bus.output_rdy_from_io  = 1'b1;
      cycle();
      check("bc_rdy", 32'(bus.out_rdy_to_dev), 32'h3);
      for (int n = 1; n <= 9; n++) begin
         if (n == 3) bus.out_ack_from_dev[0] = 1'b1;
         if (n == 9) bus.out_ack_from_dev[1] = 1'b1;
         if (n == 3 || n == 9) check("bc_data", 32'(bus.out_data_to_dev), 32'h16);
         cycle();
         check("bc_oack", 32'(bus.output_ack_to_io), 32'(n == 9));
         if (n == 3) check("bc_rdy_after_prn", 32'(bus.out_rdy_to_dev), 32'h2);
      end
      bus.output_rdy_from_io = 1'b0;
      cycle();
      bus.out_ack_from_dev = 2'b00;
      cycle();
      check("bc_done_busy", 32'(bus.out_busy_to_pnl), 32'd0);

      // Punch never acks: watchdog faults it after TB_TIMEOUT send cycles
      bus.out_enable_from_pnl = 2'b11;
      bus.output_data_from_io = 5'h0a;
      bus.output_rdy_from_io  = 1'b1;
      bus.out_ack_from_dev    = 2'b01;
      cnt = 0;
      while (cnt < 40) begin
         cycle();
         cnt++;
         if (bus.output_ack_to_io) break;
      end
      check("wd_cycles", 32'(cnt), 32'(TB_TIMEOUT + 1));
      check("wd_fault", 32'(bus.out_fault_to_pnl), 32'h2);
      bus.output_rdy_from_io = 1'b0;
      cycle();
      bus.out_ack_from_dev = 2'b00;
      cycle();
      check("wd_idle", 32'(bus.out_busy_to_pnl), 32'd0);
      check("wd_sticky", 32'(bus.out_fault_to_pnl), 32'h2);
      bus.clear_fault_from_pnl = 1'b1;
      cycle();
      bus.clear_fault_from_pnl = 1'b0;
      check("wd_clear", 32'(bus.out_fault_to_pnl), 32'h0);

      // No writers enabled: the character is acknowledged immediately
      bus.out_enable_from_pnl = 2'b00;
      bus.output_data_from_io = 5'h06;
      bus.output_rdy_from_io  = 1'b1;
      cycle();
      check("sink_oack", 32'(bus.output_ack_to_io), 32'd1);
      check("sink_rdy", 32'(bus.out_rdy_to_dev), 32'd0);
      bus.output_rdy_from_io = 1'b0;
      repeat (2) cycle();
      check("sink_idle", 32'(bus.out_busy_to_pnl), 32'd0);

      // Reset while acking io abandons the transfer
      bus.output_rdy_from_io = 1'b1;
      bus.in_enable_from_pnl = 2'b01;
      bus.input_rdy_from_io  = 1'b1;
      cycle();
      check("rst_pre_oack", 32'(bus.output_ack_to_io), 32'd1);
      resetn = 1'b0;
      cycle();
      check_all_zero("rst_mid");
      resetn = 1'b1;
      bus.output_rdy_from_io = 1'b0;
      bus.input_rdy_from_io  = 1'b0;
      cycle();
      check("rst_no_replay", 32'(bus.output_ack_to_io), 32'd0);

      // Randomized traffic, checked by the model only
      dead = 2'b00;
      vals = 2'b00;
      acks = 2'b00;
      for (int c = 0; c < 4000; c++) begin
         resetn = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 15) == 0) bus.in_enable_from_pnl  = 2'($urandom);
         if ($urandom_range(0, 15) == 0) bus.out_enable_from_pnl = 2'($urandom);
         if ($urandom_range(0, 63) == 0) dead = 2'($urandom);
         bus.input_rdy_from_io = bus.input_val_to_io ? 1'($urandom_range(0, 1))
                                                     : ($urandom_range(0, 3) != 0);
         bus.output_rdy_from_io = bus.output_ack_to_io ? 1'($urandom_range(0, 1))
                                                       : ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 2) == 0) vals[k] = ~vals[k];
            if ($urandom_range(0, 3) == 0) acks[k] = ~acks[k];
         end
         bus.in_val_from_dev      = vals;
         bus.out_ack_from_dev     = acks & ~dead;
         bus.in_data_from_dev0    = 5'($urandom);
         bus.in_data_from_dev1    = 5'($urandom);
         bus.output_data_from_io  = 5'($urandom);
         bus.clear_fault_from_pnl = ($urandom_range(0, 24) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_dev_arbiter.md
IO_DEV_ARBITER -- requirements
Module: io_dev_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: output-device watchdog limit, in clk cycles.
REQ-002 Parameter TO_W, default 11: watchdog counter width; TO_W SHALL be at least clog2(TIMEOUT_CYCLES)+1.
REQ-003 clk  in  1  clock.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 input_rdy_from_io  in  1  I/O unit ready to take an input character (level).
REQ-006 input_val_to_io / input_data_to_io  out  1/5  character offered to the I/O unit.
REQ-007 output_rdy_from_io / output_data_from_io  in  1/5  character offered by the I/O unit.
REQ-008 output_ack_to_io  out  1  character consumed by the enabled output devices.
REQ-009 in_rdy_to_dev  out  2  per-reader ready (0 = photo-reader, 1 = host link).
REQ-010 in_val_from_dev  in  2  per-reader valid; in_data_from_dev0/1  in  5  reader data.
REQ-011 out_rdy_to_dev  out  2  per-writer ready (0 = printer, 1 = punch); out_data_to_dev  out  5  broadcast data.
REQ-012 out_ack_from_dev  in  2  per-writer acknowledge.
REQ-013 in_enable_from_pnl, out_enable_from_pnl  in  2 each  panel device enables (level).
REQ-014 clear_fault_from_pnl  in  1  pulse; out_fault_to_pnl  out  2  sticky per-writer timeout flags.
REQ-015 in_busy_to_pnl, out_busy_to_pnl  out  1 each  high whenever the input or output FSM is not in IDLE.

Function
REQ-016 All handshakes SHALL be four-phase level: rdy, then val/ack rises, then rdy falls, then val/ack falls.
REQ-017 Input FSM states SHALL be I_IDLE, I_WAIT, I_VAL, I_DROP.
REQ-018 I_IDLE -> I_WAIT when input_rdy_from_io=1 and in_enable!=0; grant g is the enabled reader other than last_grant if that reader is enabled, else the single enabled reader.
REQ-019 In I_WAIT, in_rdy_to_dev[g]=1; on in_val_from_dev[g]=1 the FSM SHALL latch in_data_from_devg and go to I_VAL.
REQ-020 I_WAIT -> I_IDLE with no capture if in_enable[g] or input_rdy_from_io falls.
REQ-021 In I_VAL, input_val_to_io=1 with the latched data and in_rdy_to_dev=0; when input_rdy_from_io=0 the FSM SHALL go to I_DROP.
REQ-022 In I_DROP, input_val_to_io=0; when in_val_from_dev[g]=0 the FSM SHALL set last_grant<=g and go to I_IDLE.
REQ-023 input_data_to_io SHALL be 0 outside I_VAL.
REQ-024 Output FSM states SHALL be O_IDLE, O_SEND, O_ACK, O_REL.
REQ-025 O_IDLE with output_rdy_from_io=1: latch data and mask<=out_enable; mask!=0 -> O_SEND; mask==0 -> O_ACK (sink mode, character discarded).
REQ-026 In O_SEND, out_rdy_to_dev=mask&~done and out_data_to_dev=latched data; ack[k]=1 with mask[k]=1 SHALL set done[k].
REQ-027 O_SEND -> O_ACK when done==mask.
REQ-028 The watchdog SHALL clear on entry to O_SEND and increment each O_SEND cycle.
REQ-029 When the watchdog reaches TIMEOUT_CYCLES, every k with mask[k]&~done[k] SHALL set out_fault_to_pnl[k], clear mask[k], and the FSM SHALL go to O_ACK.
REQ-030 In O_ACK, output_ack_to_io=1; when output_rdy_from_io=0 the FSM SHALL go to O_REL.
REQ-031 In O_REL, output_ack_to_io=0; when (out_ack_from_dev&mask)==0 the FSM SHALL clear done and go to O_IDLE.
REQ-032 out_data_to_dev SHALL be 0 in O_IDLE.
REQ-033 Panel enable changes SHALL take effect only at the next O_IDLE exit; a mid-transfer change SHALL NOT alter mask.
REQ-034 Acks from unmasked writers SHALL be ignored.
REQ-035 clear_fault_from_pnl SHALL clear out_fault_to_pnl; if it coincides with a fault set, set SHALL win.
REQ-036 The input and output FSMs SHALL run independently and concurrently.

Reset
REQ-037 On resetn=0 at a clk edge: both FSMs to IDLE, all outputs 0, data latches 0, mask/done 0, watchdog 0, faults 0.
REQ-038 On resetn=0 at a clk edge: last_grant=1, so reader 0 wins the first grant.
REQ-039 Reset mid-handshake SHALL abandon the transfer with no replay.

Structure
REQ-040 FSM state encodings and device indices SHALL live in the shared io definitions include; TIMEOUT_CYCLES SHALL remain a module parameter.
REQ-041 Per-writer done/fault tracking SHALL be a sub-module io_out_lane, instantiated twice.

Verification
REQ-042 Both readers enabled, both val high with data 5'h12 / 5'h05, three io requests -> characters 12, 05, 12 (round-robin), last_grant alternates.
REQ-043 Only reader 1 enabled, disable it while in I_WAIT -> return to I_IDLE, input_val_to_io stays 0.
REQ-044 Both writers enabled, data 5'h16, printer acks at cycle 3, punch at cycle 9 -> output_ack_to_io rises only after cycle 9; both writers see 5'h16.
REQ-045 TIMEOUT_CYCLES=16, punch never acks -> out_fault_to_pnl=2'b10 after 16 O_SEND cycles, io handshake completes; clear_fault_from_pnl pulse -> 2'b00.
REQ-046 out_enable=0, io offers 5'h06 -> output_ack_to_io high next cycle, out_rdy_to_dev stays 0.
REQ-047 resetn low during O_ACK -> next cycle all outputs 0, out_busy_to_pnl=0.
